// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath geometry, architectural register indices and control-bundle bit positions.
// Also holds the forwarding-source encoding that the operand muxes use.
package cpu_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 4;

    localparam logic [ADDR_WIDTH-1:0] NO_REG  = 4'hF;
    localparam logic [ADDR_WIDTH-1:0] REG_SP  = 4'd8;
    localparam logic [ADDR_WIDTH-1:0] REG_EPC = 4'd9;
    localparam logic [ADDR_WIDTH-1:0] REG_ESP = 4'd10;
    localparam logic [ADDR_WIDTH-1:0] REG_IH  = 4'd11;
    localparam logic [ADDR_WIDTH-1:0] REG_RA  = 4'd12;

    localparam int CTRL_MEMREAD = 0;

    typedef enum logic [1:0] {
        FWD_RF,
        FWD_EX,
        FWD_WB
    } fwd_sel_e;

endpackage

// File: rtl/forward_mux.sv
// Per-operand forwarding select: EX/MEM result, then MEM/WB value, then the register-file read.
// Only architectural addresses (0..REG_RA) may match; higher codes never forward.
module forward_mux #(
    parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = cpu_pkg::ADDR_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] rf_value,
    input  logic [ADDR_WIDTH-1:0] ex_dest,
    input  logic [DATA_WIDTH-1:0] ex_value,
    input  logic [ADDR_WIDTH-1:0] wb_dest,
    input  logic [DATA_WIDTH-1:0] wb_value,
    output logic [DATA_WIDTH-1:0] value
);
    import cpu_pkg::*;

    logic     arch_addr;
    fwd_sel_e sel;

    assign arch_addr = (addr <= ADDR_WIDTH'(REG_RA));

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        sel = FWD_RF;
        if (arch_addr && ex_dest == addr) begin
            sel = FWD_EX;
        end else if (arch_addr && wb_dest == addr) begin
            sel = FWD_WB;
        end
    end

    always_comb begin
        value = rf_value;
        case (sel)
            FWD_EX:  value = ex_value;
            FWD_WB:  value = wb_value;
            default: value = rf_value;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use bubble insertion, hold and flush.
// Define WB_BYPASS_EN to enable the MEM/WB forwarding path; otherwise the regfile's falling-edge write covers WB.
module id_ex_stage #(
    parameter int                    DATA_WIDTH = cpu_pkg::DATA_WIDTH,
    parameter int                    ADDR_WIDTH = cpu_pkg::ADDR_WIDTH,
    parameter int                    CTRL_WIDTH = 12,
    parameter logic [ADDR_WIDTH-1:0] NO_REG     = cpu_pkg::NO_REG
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] rsAddr,
    input  logic [ADDR_WIDTH-1:0] rtAddr,
    input  logic                  useRs,
    input  logic                  useRt,
    input  logic [DATA_WIDTH-1:0] rsValueIn,
    input  logic [DATA_WIDTH-1:0] rtValueIn,
    input  logic [DATA_WIDTH-1:0] immIn,
    input  logic [CTRL_WIDTH-1:0] ctrlIn,
    input  logic [ADDR_WIDTH-1:0] destIn,
    input  logic                  validIn,
    input  logic [ADDR_WIDTH-1:0] exMemDest,
    input  logic [DATA_WIDTH-1:0] exMemValue,
    input  logic [ADDR_WIDTH-1:0] memWbDest,
    input  logic [DATA_WIDTH-1:0] memWbValue,
    input  logic                  holdIn,
    input  logic                  flushIn,
    output logic [DATA_WIDTH-1:0] rsValueOut,
    output logic [DATA_WIDTH-1:0] rtValueOut,
    output logic [DATA_WIDTH-1:0] immOut,
    output logic [CTRL_WIDTH-1:0] ctrlOut,
    output logic [ADDR_WIDTH-1:0] destOut,
    output logic                  validOut,
    output logic                  loadUseStall
);
    import cpu_pkg::*;

    logic [ADDR_WIDTH-1:0] wb_dest;
    logic [DATA_WIDTH-1:0] wb_value;
    logic [DATA_WIDTH-1:0] rs_fwd;
    logic [DATA_WIDTH-1:0] rt_fwd;
    logic                  dest_live;

`ifdef WB_BYPASS_EN
    assign wb_dest  = memWbDest;
    assign wb_value = memWbValue;
`else
    // An out-of-range destination can never match, so the WB path folds away.
    logic unused_wb;
    assign wb_dest   = NO_REG;
    assign wb_value  = '0;
    assign unused_wb = ^{memWbDest, memWbValue};
`endif

    forward_mux #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_fwd_rs (
        .addr     (rsAddr),
        .rf_value (rsValueIn),
        .ex_dest  (exMemDest),
        .ex_value (exMemValue),
        .wb_dest  (wb_dest),
        .wb_value (wb_value),
        .value    (rs_fwd)
    );

    forward_mux #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_fwd_rt (
        .addr     (rtAddr),
        .rf_value (rtValueIn),
        .ex_dest  (exMemDest),
        .ex_value (exMemValue),
        .wb_dest  (wb_dest),
        .wb_value (wb_value),
        .value    (rt_fwd)
    );

    // validOut is cleared by reset, which keeps the stall low while reset is held.
    assign dest_live    = (destOut != NO_REG) && (destOut <= ADDR_WIDTH'(REG_RA));
    assign loadUseStall = validOut && ctrlOut[CTRL_MEMREAD] && dest_live &&
                          ((useRs && rsAddr == destOut) || (useRt && rtAddr == destOut));

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rsValueOut <= '0;
            rtValueOut <= '0;
            immOut     <= '0;
            ctrlOut    <= '0;
            destOut    <= NO_REG;
            validOut   <= 1'b0;
        end else if (holdIn) begin
            rsValueOut <= rsValueOut;
        end else if (flushIn || loadUseStall) begin
            // Bubble: operands are don't-care once validOut drops, so they simply hold.
            ctrlOut  <= '0;
            destOut  <= NO_REG;
            validOut <= 1'b0;
        end else begin
            rsValueOut <= rs_fwd;
            rtValueOut <= rt_fwd;
            immOut     <= immIn;
            ctrlOut    <= ctrlIn;
            destOut    <= destIn;
            validOut   <= validIn;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scoreboard bench for id_ex_stage: expected stage contents are queued at drive time
// and compared one cycle later; the load-use stall is compared combinationally before each edge.
module tb_id_ex_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  rsAddr, rtAddr, destIn, exMemDest, memWbDest;
    logic        useRs, useRt, validIn, holdIn, flushIn;
    logic [15:0] rsValueIn, rtValueIn, immIn, exMemValue, memWbValue;
    logic [11:0] ctrlIn;
    logic [15:0] rsValueOut, rtValueOut, immOut;
    logic [11:0] ctrlOut;
    logic [3:0]  destOut;
    logic        validOut, loadUseStall;

    typedef struct {
        string       tag;
        logic [15:0] rs;
        logic [15:0] rt;
        logic [15:0] imm;
        logic [11:0] ctrl;
        logic [3:0]  dest;
        logic        valid;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

`ifdef WB_BYPASS_EN
    localparam logic [15:0] WB_EXP = 16'h00A5;
`else
    localparam logic [15:0] WB_EXP = 16'h0000;
`endif

    id_ex_stage dut (
        .clock        (clock),
        .reset        (reset),
        .rsAddr       (rsAddr),
        .rtAddr       (rtAddr),
        .useRs        (useRs),
        .useRt        (useRt),
        .rsValueIn    (rsValueIn),
        .rtValueIn    (rtValueIn),
        .immIn        (immIn),
        .ctrlIn       (ctrlIn),
        .destIn       (destIn),
        .validIn      (validIn),
        .exMemDest    (exMemDest),
        .exMemValue   (exMemValue),
        .memWbDest    (memWbDest),
        .memWbValue   (memWbValue),
        .holdIn       (holdIn),
        .flushIn      (flushIn),
        .rsValueOut   (rsValueOut),
        .rtValueOut   (rtValueOut),
        .immOut       (immOut),
        .ctrlOut      (ctrlOut),
        .destOut      (destOut),
        .validOut     (validOut),
        .loadUseStall (loadUseStall)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic decode(input logic [3:0] rsa, input logic [3:0] rta, input logic ur, input logic ut,
                          input logic [15:0] rsv, input logic [15:0] rtv, input logic [15:0] imm,
                          input logic [11:0] ctrl, input logic [3:0] dest, input logic valid);
        rsAddr = rsa; rtAddr = rta; useRs = ur; useRt = ut;
        rsValueIn = rsv; rtValueIn = rtv; immIn = imm;
        ctrlIn = ctrl; destIn = dest; validIn = valid;
    endtask

    task automatic fwd(input logic [3:0] exd, input logic [15:0] exv, input logic [3:0] wbd, input logic [15:0] wbv);
        exMemDest = exd; exMemValue = exv; memWbDest = wbd; memWbValue = wbv;
    endtask

    task automatic expect_out(input string tag, input logic [15:0] rs, input logic [15:0] rt, input logic [15:0] imm,
                              input logic [11:0] ctrl, input logic [3:0] dest, input logic valid);
        exp_t e;
        e.tag = tag; e.rs = rs; e.rt = rt; e.imm = imm; e.ctrl = ctrl; e.dest = dest; e.valid = valid;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clock);
        #1;
        n_cmp++;
        assert (sb.size() > 0) else begin
            n_fail++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, ".rs"},    32'(rsValueOut), 32'(e.rs));
            check({e.tag, ".rt"},    32'(rtValueOut), 32'(e.rt));
            check({e.tag, ".imm"},   32'(immOut),     32'(e.imm));
            check({e.tag, ".ctrl"},  32'(ctrlOut),    32'(e.ctrl));
            check({e.tag, ".dest"},  32'(destOut),    32'(e.dest));
            check({e.tag, ".valid"}, 32'(validOut),   32'(e.valid));
        end
    endtask

    task automatic check_stall(input string tag, input logic exp);
        #1;
        check(tag, 32'(loadUseStall), 32'(exp));
    endtask

    initial begin
        reset = 1'b0; holdIn = 1'b0; flushIn = 1'b0;
        decode(4'd0, 4'd0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 12'h0, 4'hF, 1'b0);
        fwd(4'hF, 16'h0, 4'hF, 16'h0);
        #12;
        check("init.rs",    32'(rsValueOut), 32'h0);
        check("init.dest",  32'(destOut),    32'hF);
        check("init.valid", 32'(validOut),   32'h0);
        check("init.stall", 32'(loadUseStall), 32'h0);
        @(negedge clock) reset = 1'b1;

        // Plain capture of a load to R6.
        decode(4'd1, 4'd5, 1'b1, 1'b1, 16'h1111, 16'h2222, 16'h00FF, 12'h001, 4'd6, 1'b1);
        check_stall("cap.stall", 1'b0);
        expect_out("cap", 16'h1111, 16'h2222, 16'h00FF, 12'h001, 4'd6, 1'b1);
        tick();

        // Dependent decode raises the stall; reset mid-cycle clears everything at once.
        decode(4'd6, 4'd0, 1'b1, 1'b0, 16'h0666, 16'h0, 16'h0, 12'h000, 4'd7, 1'b1);
        check_stall("pre_reset.stall", 1'b1);
        @(negedge clock) reset = 1'b0;
        #1;
        check("rst.rs",    32'(rsValueOut),   32'h0);
        check("rst.rt",    32'(rtValueOut),   32'h0);
        check("rst.imm",   32'(immOut),       32'h0);
        check("rst.ctrl",  32'(ctrlOut),      32'h0);
        check("rst.dest",  32'(destOut),      32'hF);
        check("rst.valid", 32'(validOut),     32'h0);
        check("rst.stall", 32'(loadUseStall), 32'h0);
        @(negedge clock) reset = 1'b1;

        // EX/MEM wins over MEM/WB on the same address.
        decode(4'd3, 4'd7, 1'b1, 1'b1, 16'h0001, 16'h7777, 16'h0010, 12'h002, 4'd4, 1'b1);
        fwd(4'd3, 16'hBEEF, 4'd3, 16'h1234);
        expect_out("ex_fwd", 16'hBEEF, 16'h7777, 16'h0010, 12'h002, 4'd4, 1'b1);
        tick();

        // MEM/WB forward of RA, present only with the bypass build.
        decode(4'd0, 4'd12, 1'b1, 1'b1, 16'h0A0A, 16'h0000, 16'h0020, 12'h004, 4'd1, 1'b1);
        fwd(4'hF, 16'h0000, 4'd12, 16'h00A5);
        expect_out("wb_fwd", 16'h0A0A, WB_EXP, 16'h0020, 12'h004, 4'd1, 1'b1);
        tick();

        // Addresses above RA never match a forwarding destination.
        decode(4'd13, 4'd15, 1'b1, 1'b1, 16'h1313, 16'h1515, 16'h0030, 12'h008, 4'd3, 1'b1);
        fwd(4'd13, 16'hDEAD, 4'd15, 16'hCAFE);
        expect_out("no_fwd_hi", 16'h1313, 16'h1515, 16'h0030, 12'h008, 4'd3, 1'b1);
        tick();

        // Load-use on rs: one bubble, then EX/MEM supplies the loaded value.
        decode(4'd4, 4'd5, 1'b1, 1'b1, 16'h0404, 16'h0505, 16'h0040, 12'h001, 4'd2, 1'b1);
        fwd(4'hF, 16'h0, 4'hF, 16'h0);
        expect_out("load", 16'h0404, 16'h0505, 16'h0040, 12'h001, 4'd2, 1'b1);
        tick();
        decode(4'd2, 4'd6, 1'b1, 1'b1, 16'h0BAD, 16'h0606, 16'h0050, 12'h010, 4'd5, 1'b1);
        check_stall("lu.stall", 1'b1);
        expect_out("lu_bubble", 16'h0404, 16'h0505, 16'h0040, 12'h000, 4'hF, 1'b0);
        tick();
        check_stall("lu.after_bubble", 1'b0);
        fwd(4'd2, 16'h5555, 4'hF, 16'h0);
        expect_out("lu_replay", 16'h5555, 16'h0606, 16'h0050, 12'h010, 4'd5, 1'b1);
        tick();

        // Same load, but the consumer does not read rs/rt: no stall.
        decode(4'd1, 4'd1, 1'b1, 1'b1, 16'h0111, 16'h0111, 16'h0060, 12'h001, 4'd2, 1'b1);
        fwd(4'hF, 16'h0, 4'hF, 16'h0);
        expect_out("load2", 16'h0111, 16'h0111, 16'h0060, 12'h001, 4'd2, 1'b1);
        tick();
        decode(4'd2, 4'd2, 1'b0, 1'b0, 16'h0222, 16'h0333, 16'h0070, 12'h020, 4'd6, 1'b1);
        check_stall("false.stall", 1'b0);
        expect_out("false_cap", 16'h0222, 16'h0333, 16'h0070, 12'h020, 4'd6, 1'b1);
        tick();

        // A non-load producer never stalls a reader.
        decode(4'd8, 4'd6, 1'b1, 1'b1, 16'h0808, 16'h0909, 16'h0080, 12'h001, 4'd7, 1'b1);
        check_stall("nonload.stall", 1'b0);

        // Hold beats flush for two cycles; releasing hold lets the flush bubble through.
        holdIn = 1'b1; flushIn = 1'b1;
        expect_out("hold1", 16'h0222, 16'h0333, 16'h0070, 12'h020, 4'd6, 1'b1);
        tick();
        expect_out("hold2", 16'h0222, 16'h0333, 16'h0070, 12'h020, 4'd6, 1'b1);
        tick();
        holdIn = 1'b0;
        expect_out("flush", 16'h0222, 16'h0333, 16'h0070, 12'h000, 4'hF, 1'b0);
        tick();
        flushIn = 1'b0;

        // Flush together with load-use yields exactly one bubble.
        decode(4'd8, 4'd9, 1'b1, 1'b1, 16'h0A01, 16'h0A02, 16'h0090, 12'h001, 4'd2, 1'b1);
        expect_out("load3", 16'h0A01, 16'h0A02, 16'h0090, 12'h001, 4'd2, 1'b1);
        tick();
        decode(4'd2, 4'd9, 1'b1, 1'b1, 16'h0B01, 16'h0B02, 16'h00A0, 12'h040, 4'd3, 1'b1);
        flushIn = 1'b1;
        check_stall("fl_lu.stall", 1'b1);
        expect_out("fl_lu_bubble", 16'h0A01, 16'h0A02, 16'h0090, 12'h000, 4'hF, 1'b0);
        tick();
        flushIn = 1'b0;
        fwd(4'd2, 16'h7777, 4'hF, 16'h0);
        expect_out("fl_lu_replay", 16'h7777, 16'h0B02, 16'h00A0, 12'h040, 4'd3, 1'b1);
        tick();

        // An invalid load slot does not stall a dependent reader.
        decode(4'd0, 4'd0, 1'b0, 1'b0, 16'h0C01, 16'h0C02, 16'h00B0, 12'h001, 4'd2, 1'b0);
        fwd(4'hF, 16'h0, 4'hF, 16'h0);
        expect_out("inv_load", 16'h0C01, 16'h0C02, 16'h00B0, 12'h001, 4'd2, 1'b0);
        tick();
        decode(4'd2, 4'd2, 1'b1, 1'b1, 16'h0D01, 16'h0D02, 16'h00C0, 12'h000, 4'd4, 1'b1);
        check_stall("inv.stall", 1'b0);

        check("sb.drained", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
